// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory burst master and its bank.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead
    } mem_burst_state_e;

    function automatic int unsigned data_bytes(input int unsigned data_size);
        return 32'd1 << data_size;
    endfunction

    function automatic int unsigned data_width(input int unsigned data_size);
        return 8 * data_bytes(data_size);
    endfunction

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for a byte-strobed memory bank: one command at a time, write beats
// streamed straight through to the bank, read beats returned through a one-stage register.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataSize  = 2,
    parameter int unsigned LenWidth  = 4,
    localparam int unsigned DataBytes = data_bytes(DataSize),
    localparam int unsigned DataWidth = data_width(DataSize)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataBytes-1:0] wstrb_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rdata_last_o,
    output logic                 rdata_valid_o,
    input  logic                 rdata_ready_i,
    output logic                 done_o,
    output logic                 mem_cs_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataBytes-1:0] mem_wstrb_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(DataBytes);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(DataBytes - 1);

    mem_burst_state_e     state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 rlast_q, rlast_d;
    logic                 rvalid_q, rvalid_d;
    logic                 done_q, done_d;
    logic                 fetch;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        rdata_d       = rdata_q;
        rlast_d       = rlast_q;
        rvalid_d      = rvalid_q;
        // A read burst completes when its last beat leaves the output register.
        done_d        = rvalid_q & rdata_ready_i & rlast_q;
        fetch         = 1'b0;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        mem_cs_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;

        if (rvalid_q && rdata_ready_i) begin
            rvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready_o = ~rvalid_q;
                if (cmd_valid_i && !rvalid_q) begin
                    addr_d  = cmd_addr_i & AlignMask;
                    rem_d   = cmd_len_i;
                    state_d = cmd_write_i ? StWrite : StRead;
                end
            end
            StWrite: begin
                wdata_ready_o = 1'b1;
                mem_cs_o      = wdata_valid_i;
                mem_addr_o    = addr_q;
                mem_wdata_o   = wdata_i;
                mem_wstrb_o   = wstrb_i;
                if (wdata_valid_i) begin
                    addr_d = addr_q + AddrStep;
                    rem_d  = rem_q - LenWidth'(1);
                    if (rem_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StRead: begin
                fetch      = ~rvalid_q | rdata_ready_i;
                mem_cs_o   = fetch;
                mem_addr_o = addr_q;
                if (fetch) begin
                    rdata_d  = mem_rdata_i;
                    rvalid_d = 1'b1;
                    rlast_d  = (rem_q == '0);
                    addr_d   = addr_q + AddrStep;
                    rem_d    = rem_q - LenWidth'(1);
                    if (rem_q == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset must silence the bank and both handshakes combinationally.
        if (rst_i) begin
            cmd_ready_o   = 1'b0;
            wdata_ready_o = 1'b0;
            mem_cs_o      = 1'b0;
            mem_wstrb_o   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            rem_q    <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_last_o  = rlast_q;
    assign rdata_valid_o = rvalid_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 256-byte bank attached.
module tb_mem_burst_master;

    localparam int unsigned AddrWidth = 8;
    localparam int unsigned DataSize  = 2;
    localparam int unsigned LenWidth  = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [7:0]  cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [31:0] rdata_o;
    logic        rdata_last_o;
    logic        rdata_valid_o;
    logic        rdata_ready_i;
    logic        done_o;
    logic        mem_cs_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] bank [256];
    logic       mem_clr;

    always #5 clk_i = ~clk_i;

    mem_burst_master #(
        .AddrWidth(AddrWidth),
        .DataSize (DataSize),
        .LenWidth (LenWidth)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .wdata_i      (wdata_i),
        .wstrb_i      (wstrb_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .rdata_o      (rdata_o),
        .rdata_last_o (rdata_last_o),
        .rdata_valid_o(rdata_valid_o),
        .rdata_ready_i(rdata_ready_i),
        .done_o       (done_o),
        .mem_cs_o     (mem_cs_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Bank model: combinational read, byte-strobed write on the clock edge.
    always @(posedge clk_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
        end else if (mem_cs_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb_o[b]) bank[mem_addr_o + 8'(b)] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_rdata_i = '0;
        for (int b = 0; b < 4; b++) mem_rdata_i[8*b +: 8] = bank[mem_addr_o + 8'(b)];
    end

    function automatic logic [31:0] bank_word(input logic [7:0] a);
        return {bank[a + 8'd3], bank[a + 8'd2], bank[a + 8'd1], bank[a]};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len);
        bit ok = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = cmd_ready_o;
            step();
        end
        cmd_valid_i = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept: got no cmd_ready_o within 20 cycles, want accept");
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cmd_valid_i = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready_o);
        end
        n_checks++;
        if (mem_cs_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mem_cs: got %b want 0", mem_cs_o);
        end
        cmd_valid_i = 1'b0;
        rst_i = 1'b0;
        mem_clr = 1'b0;
        #1;
        n_checks++;
        if ({rdata_valid_o, rdata_last_o, done_o, rdata_o} !== 35'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: got v%b l%b d%b %h want all 0",
                     rdata_valid_o, rdata_last_o, done_o, rdata_o);
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1 || mem_addr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_idle: got ready %b addr %h want 1 00", cmd_ready_o, mem_addr_o);
        end
        step();
    endtask

    task automatic test_write();
        logic [31:0] exp_w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        start_cmd(1'b1, 8'h10, 4'd3);
        wdata_valid_i = 1'b1;
        wstrb_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wdata_i = exp_w[i];
            #1;
            n_checks++;
            if (mem_cs_o !== 1'b1 || wdata_ready_o !== 1'b1 || mem_addr_o !== 8'(8'h10 + 4 * i)
                || mem_wstrb_o !== 4'hF || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_beat%0d: got cs %b rdy %b addr %h strb %h done %b want 1 1 %h f 0",
                         i, mem_cs_o, wdata_ready_o, mem_addr_o, mem_wstrb_o, done_o,
                         8'(8'h10 + 4 * i));
            end
            step();
        end
        wdata_valid_i = 1'b0;
        #1;
        n_checks++;
        if (done_o !== 1'b1 || mem_cs_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done: got done %b cs %b ready %b want 1 0 1",
                     done_o, mem_cs_o, cmd_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bank_word(8'(8'h10 + 4 * i)) !== exp_w[i]) begin
                n_fail++;
                $display("FAIL wr_bank%0d: got %h want %h", i, bank_word(8'(8'h10 + 4 * i)),
                         exp_w[i]);
            end
        end
        step();
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_pulse: got %b want 0", done_o);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] exp_w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        rdata_ready_i = 1'b0;
        start_cmd(1'b0, 8'h10, 4'd3);
        #1;
        n_checks++;
        if (mem_cs_o !== 1'b1 || mem_addr_o !== 8'h10 || mem_wstrb_o !== 4'h0
            || rdata_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_first: got cs %b addr %h strb %h valid %b want 1 10 0 0",
                     mem_cs_o, mem_addr_o, mem_wstrb_o, rdata_valid_o);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (mem_cs_o !== 1'b0 || rdata_valid_o !== 1'b1 || rdata_o !== 32'h11111111
                || rdata_last_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_stall%0d: got cs %b valid %b data %h last %b want 0 1 11111111 0",
                         c, mem_cs_o, rdata_valid_o, rdata_o, rdata_last_o);
            end
            step();
        end
        rdata_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            n_checks++;
            if (mem_cs_o !== 1'b1 || mem_addr_o !== 8'(8'h10 + 4 * k)
                || rdata_o !== exp_w[k-1] || rdata_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_beat%0d: got cs %b addr %h data %h valid %b want 1 %h %h 1", k,
                         mem_cs_o, mem_addr_o, rdata_o, rdata_valid_o, 8'(8'h10 + 4 * k),
                         exp_w[k-1]);
            end
            step();
        end
        #1;
        n_checks++;
        if (rdata_o !== 32'h44444444 || rdata_last_o !== 1'b1 || rdata_valid_o !== 1'b1
            || mem_cs_o !== 1'b0 || cmd_ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_last: got data %h last %b valid %b cs %b ready %b done %b want 44444444 1 1 0 0 0",
                     rdata_o, rdata_last_o, rdata_valid_o, mem_cs_o, cmd_ready_o, done_o);
        end
        step();
        n_checks++;
        if (done_o !== 1'b1 || rdata_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_done: got done %b valid %b ready %b want 1 0 1",
                     done_o, rdata_valid_o, cmd_ready_o);
        end
        step();
    endtask

    task automatic test_unaligned();
        start_cmd(1'b1, 8'h13, 4'd0);
        wdata_i = 32'hAABBCCDD;
        wstrb_i = 4'b0101;
        wdata_valid_i = 1'b1;
        #1;
        n_checks++;
        if (mem_addr_o !== 8'h10 || mem_cs_o !== 1'b1 || mem_wstrb_o !== 4'b0101) begin
            n_fail++;
            $display("FAIL unal_addr: got addr %h cs %b strb %b want 10 1 0101",
                     mem_addr_o, mem_cs_o, mem_wstrb_o);
        end
        step();
        wdata_valid_i = 1'b0;
        n_checks++;
        if (done_o !== 1'b1 || bank_word(8'h10) !== 32'h11BB11DD) begin
            n_fail++;
            $display("FAIL unal_bank: got done %b word %h want 1 11bb11dd",
                     done_o, bank_word(8'h10));
        end
        rdata_ready_i = 1'b1;
        start_cmd(1'b0, 8'h10, 4'd0);
        step();
        n_checks++;
        if (rdata_o !== 32'h11BB11DD || rdata_last_o !== 1'b1 || rdata_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL unal_read: got data %h last %b valid %b want 11bb11dd 1 1",
                     rdata_o, rdata_last_o, rdata_valid_o);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        start_cmd(1'b1, 8'hF8, 4'd3);
        wdata_valid_i = 1'b1;
        wstrb_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wdata_i = 32'hCAFE0000 + 32'(i);
            step();
        end
        wdata_valid_i = 1'b0;
        rdata_ready_i = 1'b1;
        start_cmd(1'b0, 8'hF8, 4'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (mem_cs_o !== 1'b1 || mem_addr_o !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got cs %b addr %h want 1 %h",
                         i, mem_cs_o, mem_addr_o, exp_a[i]);
            end
            step();
            n_checks++;
            if (rdata_o !== 32'hCAFE0000 + 32'(i) || rdata_last_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_data%0d: got %h last %b want %h %b", i, rdata_o,
                         rdata_last_o, 32'hCAFE0000 + 32'(i), (i == 3));
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        rdata_ready_i = 1'b1;
        start_cmd(1'b0, 8'h10, 4'd1);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 8'h40;
        cmd_len_i   = 4'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (cmd_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL b2b_hold%0d: got ready %b want 0", c, cmd_ready_o);
            end
            step();
        end
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got ready %b done %b want 1 1", cmd_ready_o, done_o);
        end
        step();
        cmd_valid_i = 1'b0;
        wdata_i = 32'h5A5A5A5A;
        wstrb_i = 4'hF;
        wdata_valid_i = 1'b1;
        #1;
        n_checks++;
        if (mem_cs_o !== 1'b1 || mem_addr_o !== 8'h40 || mem_wstrb_o !== 4'hF) begin
            n_fail++;
            $display("FAIL b2b_write: got cs %b addr %h strb %h want 1 40 f",
                     mem_cs_o, mem_addr_o, mem_wstrb_o);
        end
        step();
        wdata_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        start_cmd(1'b1, 8'h80, 4'd3);
        wdata_valid_i = 1'b1;
        wstrb_i = 4'hF;
        for (int i = 0; i < 2; i++) begin
            wdata_i = 32'h77770000 + 32'(i);
            step();
        end
        wdata_i = 32'hDEADBEEF;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (mem_cs_o !== 1'b0 || wdata_ready_o !== 1'b0 || mem_wstrb_o !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_cs: got cs %b rdy %b strb %h want 0 0 0",
                     mem_cs_o, wdata_ready_o, mem_wstrb_o);
        end
        step();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (done_o !== 1'b0 || mem_cs_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle: got done %b cs %b ready %b want 0 0 1",
                     done_o, mem_cs_o, cmd_ready_o);
        end
        n_checks++;
        if (bank_word(8'h84) !== 32'h77770001 || bank_word(8'h88) !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_bank: got %h %h want 77770001 00000000",
                     bank_word(8'h84), bank_word(8'h88));
        end
        wdata_valid_i = 1'b0;
        step();
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_done: got %b want 0", done_o);
        end
    endtask

    initial begin
        mem_clr       = 1'b1;
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_write_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_len_i     = '0;
        wdata_i       = '0;
        wstrb_i       = '0;
        wdata_valid_i = 1'b0;
        rdata_ready_i = 1'b0;
        test_reset();
        test_write();
        test_read_stall();
        test_unaligned();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
Initiator for the byte-strobed memory bank interface (cs, addr, wdata, wstrb, combinational rdata, write on the clock edge). It accepts one burst command at a time over a valid/ready handshake. It then runs sequential word-aligned write beats, taken from a write-data stream, or read beats, delivered on a registered read-data stream. It sits between a bus or DMA front-end and one mem_bank instance.

Parameters:
AddrWidth, 8, byte address width; must equal the attached bank's AddrWidth.
DataSize, 2, log2 of bytes per word; DataBytes = 2**DataSize, DataWidth = 8*DataBytes (localparams).
LenWidth, 4, width of the beat-count field; a burst is cmd_len_i+1 beats (1..2**LenWidth).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  AddrWidth  start byte address; low DataSize bits ignored
cmd_len_i  in  LenWidth  beats minus one
wdata_i  in  DataWidth  write beat data
wstrb_i  in  DataBytes  write beat byte strobes
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat accepted when valid&ready
rdata_o  out  DataWidth  read beat data (registered)
rdata_last_o  out  1  marks final read beat (registered)
rdata_valid_o  out  1  read beat valid (registered)
rdata_ready_i  in  1  consumer accepts read beat
done_o  out  1  one-cycle pulse, burst complete
mem_cs_o  out  1  bank chip select
mem_addr_o  out  AddrWidth  bank byte address, low DataSize bits always 0
mem_wdata_o  out  DataWidth  bank write data
mem_wstrb_o  out  DataBytes  bank byte write enables
mem_rdata_i  in  DataWidth  bank read data (combinational from mem_addr_o)

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). All registers clear on a clk_i edge with rst_i=1.
- Reset values: state IDLE; rdata_o=0, rdata_last_o=0, rdata_valid_o=0, done_o=0. Address and remaining-count registers are 0.
- While rst_i=1: mem_cs_o=0, mem_wstrb_o=0, cmd_ready_o=0, wdata_ready_o=0, regardless of state.
- States: IDLE, WRITE, READ.
- IDLE: cmd_ready_o = ~rdata_valid_o, so a read must fully drain before the next command.
  - On accept, latch addr = {cmd_addr_i[AddrWidth-1:DataSize], DataSize'0} and rem = cmd_len_i.
  - Go to WRITE if cmd_write_i=1, else READ.
- WRITE:
  - wdata_ready_o=1.
  - mem_cs_o = wdata_valid_i; mem_wdata_o = wdata_i; mem_wstrb_o = wstrb_i.
  - The bank writes on the same edge (zero added latency).
  - Per accepted beat: addr += DataBytes, rem -= 1.
  - On the beat with rem==0: go to IDLE and set done_o=1 for the next cycle.
  - wstrb_i=0 beats still count as beats.
- READ:
  - fetch = ~rdata_valid_o | rdata_ready_i; mem_cs_o = fetch; mem_wstrb_o = 0; mem_wdata_o = 0.
  - On fetch: rdata_o <= mem_rdata_i, rdata_valid_o <= 1, rdata_last_o <= (rem==0), then addr += DataBytes and rem -= 1.
  - After the fetch with rem==0: go to IDLE.
  - Read latency: 1 cycle from bank address to rdata_valid_o.
  - Full throughput is one beat per cycle while rdata_ready_i=1.
- Output register: rdata_valid_o clears on handshake when no new fetch occurs. Data is held stable while valid&~ready.
- done_o for reads pulses the cycle after the rdata_last_o beat handshakes.
- mem_addr_o = addr register in WRITE/READ, 0 in IDLE. mem_cs_o is 0 in IDLE.
- Address wraps modulo 2**AddrWidth; no error is raised.
- Commands are never accepted outside IDLE. A command presented during a burst is held by its source.
- Reset mid-burst aborts immediately: no further mem_cs_o, pending rdata is discarded, no done_o.

Decomposition:
- Shared package mem_pkg holds the state typedef mem_burst_state_e (IDLE, WRITE, READ) and the localparam functions for DataBytes/DataWidth.
- No sub-module: the read output register is small enough to stay inline.

Test Plan:
- Write 4 beats at 0x10, data 0x11111111..0x44444444, wstrb=0xF, wdata_valid continuous -> mem_addr_o 0x10, 0x14, 0x18, 0x1C on 4 consecutive cycles with mem_cs_o=1; done_o pulses 1 cycle later; bank holds the data.
- Read 4 beats at 0x10 with rdata_ready_i=0 for cycles 2-4 -> rdata_o=0x11111111 held stable while stalled, no extra mem_cs_o; after release, beats 0x22222222, 0x33333333, 0x44444444 follow; rdata_last_o=1 on the 4th; done_o pulses after its handshake.
- Unaligned addr 0x13, len=0, write 0xAABBCCDD, wstrb=0b0101 -> mem_addr_o=0x10; only bytes 0 and 2 change; a subsequent read returns the merged word.
- Wrap: read at 0xF8, len=3 -> mem_addr_o sequence 0xF8, 0xFC, 0x00, 0x04.
- Back-to-back: write cmd held valid during a read burst -> cmd_ready_o stays 0 until the last read beat handshakes, then the command is accepted and the first write beat can issue the next cycle.
- rst_i asserted mid-write after 2 of 4 beats -> mem_cs_o=0 from that cycle; no done_o; state IDLE; cmd_ready_o=1 the cycle after rst_i deasserts.
